pixel_burst_engine: RTL and testbench
=====================================

// Module: pixel_burst_engine
// PURPOSE
//  Parametrised SRAM pixel burst engine for the edge-detector datapath. Reads N RGB words
//  from SRAM, converts each word to greyscale and holds them in a pixel buffer. Then writes
//  M buffered result pixels back to SRAM. The accesses use a programmable wait-state count.
//  Sits between the window/filter logic and the SRAM model, with a start/busy/done handshake.
// PARAMETERS
//  ADDR_W    16  SRAM address width
//  PIX_W     8   bits per grey pixel; one SRAM word = 3*PIX_W (R[23:16],G[15:8],B[7:0] at default)
//  MAX_PIX   20  pixel buffer depth, for both read and write
//  CNT_W     5   width of num_rd/num_wr; must satisfy 2**CNT_W > MAX_PIX
//  WAIT_CYC  3   clocks per SRAM access; must be >= 1
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous reset, active high
//  start      in   1              one-cycle request; sampled only in IDLE
//  rd_base    in   ADDR_W         first read address
//  wr_base    in   ADDR_W         first write address
//  num_rd     in   CNT_W          pixels to read (0..MAX_PIX)
//  num_wr     in   CNT_W          pixels to write (0..MAX_PIX)
//  wr_pix     in   MAX_PIX*PIX_W  pixels to write; entry i = bits [i*PIX_W +: PIX_W]
//  rd_pix     out  MAX_PIX*PIX_W  grey pixels read, same packing as wr_pix
//  busy       out  1              high from the cycle after start is accepted until done
//  done       out  1              one-cycle pulse when the burst completes
//  address    out  ADDR_W         SRAM address
//  w_data     out  3*PIX_W        SRAM write data
//  r_data     in   3*PIX_W        SRAM read data
//  read_enable   out  1           SRAM read strobe
//  write_enable  out  1           SRAM write strobe
// BEHAVIOUR
//  - Reset values: all outputs 0, rd_pix 0, state IDLE, all counters 0.
//  - States and transitions:
//      IDLE -> RD   on start && num_rd != 0
//      IDLE -> WR   on start && num_rd == 0 && num_wr != 0
//      IDLE -> DONE on start with both counts 0
//      RD -> WR or DONE after the last read; WR -> DONE after the last write; DONE -> IDLE.
//  - At start: latch rd_base, wr_base, num_rd and num_wr. Clamp each count to MAX_PIX.
//    Clear rd_pix to 0. Latch wr_pix and hold it for the whole burst.
//  - Access timing: each access holds address and its enable for exactly WAIT_CYC cycles.
//    A wait counter runs 0..WAIT_CYC-1.
//  - Read: on the last wait cycle, sample r_data and store grey into rd_pix[idx]; then idx++.
//  - Write: w_data is driven for all WAIT_CYC cycles of the access.
//  - Address = base + idx, modulo 2**ADDR_W, so the address wraps past the top of SRAM.
//  - Back-to-back accesses: the next access follows with no idle cycle.
//    Enables are never high in DONE or IDLE.
//  - Grey conversion: s = R+G+B, computed PIX_W+2 bits wide.
//    g = (s>>2)+(s>>4)+(s>>6)+(s>>8), truncated to PIX_W.
//    White (FF,FF,FF) gives 0xFB; black gives 0x00.
//  - Latency: done is high in cycle (num_rd+num_wr)*WAIT_CYC + 1 after the start edge.
//    busy is high for all cycles before it.
//  - rd_pix holds its value after done until the next accepted start.
//  - start while busy or in DONE: ignored, no queueing.
//  - rst mid-burst: abort; next cycle IDLE with all outputs 0; partial rd_pix is cleared.
// CONFIGURATION
//  PIXEL_BURST_GREY_REPLICATE_EN
//   defined:   w_data = {pix,pix,pix}, a grey pixel replicated on all three channels
//   undefined: w_data = {(2*PIX_W)'b0, pix}, zero-extended into the low channel
// TESTING
//  1. Reset, then start with rd_base=0x0010, num_rd=2, num_wr=0; SRAM holds FFFFFF and
//     000000 -> rd_pix[0]=FB, rd_pix[1]=00; addresses 0x0010 then 0x0011, 3 cycles each;
//     done at cycle 7.
//  2. Start with num_rd=1, num_wr=2, wr_base=0x0100, wr_pix[0]=0x12, wr_pix[1]=0x34 ->
//     read phase then writes to 0x0100 and 0x0101 (w_data 0x000012/0x000034, or
//     0x121212/0x343434 with the macro); done at cycle 10.
//  3. Both counts 0 -> done pulses at cycle 1; enables never assert.
//  4. rd_base=0xFFFF, num_rd=2 -> addresses 0xFFFF then 0x0000.
//     num_rd=31 -> clamped to 20 reads.
//  5. Pulse start again while busy -> ignored, done pulses exactly once.
//     Assert rst during the 2nd read -> IDLE and all outputs 0 on the next cycle.
//  6. Random RGB values with a reference model -> rd_pix matches the grey formula bit-exactly.

Source files
------------

// File: rtl/pixel_burst_engine.sv
// ---------------------------------------------------------------------------
// pixel_burst_engine
//
// Purpose
//   Reads a burst of RGB words from SRAM, converts each one to a grey pixel and
//   stores it in an output pixel buffer. Then writes a burst of buffered grey
//   pixels back to SRAM. Every SRAM access lasts a fixed WAIT_CYC clocks.
//   Accesses follow one another with no idle cycle.
//
// Configuration macro
//   PIXEL_BURST_GREY_REPLICATE_EN
//     defined   : w_data = {pix, pix, pix}; the grey value appears on all channels
//     undefined : w_data = {zeros, pix}; the grey value sits in the low channel
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous reset, active high
//   start         in   one-cycle burst request; looked at only while IDLE
//   rd_base       in   first read address
//   wr_base       in   first write address
//   num_rd        in   pixels to read; values above MAX_PIX are clamped
//   num_wr        in   pixels to write; values above MAX_PIX are clamped
//   wr_pix        in   pixels to write; entry i = [i*PIX_W +: PIX_W]
//   rd_pix        out  grey pixels read, packed the same way as wr_pix
//   busy          out  high while reading or writing
//   done          out  one-cycle pulse when the burst has finished
//   address       out  SRAM address (0 when no access is in progress)
//   w_data        out  SRAM write data (0 when not writing)
//   r_data        in   SRAM read data
//   read_enable   out  SRAM read strobe
//   write_enable  out  SRAM write strobe
//   state_dbg     out  current FSM state (0 IDLE, 1 RD, 2 WR, 3 DONE)
//
// Handshake
//   A start pulse in IDLE is accepted on that clock edge. busy is high from
//   the next cycle until the cycle before done. done pulses for exactly one
//   cycle, and the engine is back in IDLE on the cycle after that. start is
//   ignored while busy or done is high. Requests are not queued.
// ---------------------------------------------------------------------------
module pixel_burst_engine #(
    parameter int ADDR_W   = 16,
    parameter int PIX_W    = 8,
    parameter int MAX_PIX  = 20,
    parameter int CNT_W    = 5,
    parameter int WAIT_CYC = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        rd_base,
    input  logic [ADDR_W-1:0]        wr_base,
    input  logic [CNT_W-1:0]         num_rd,
    input  logic [CNT_W-1:0]         num_wr,
    input  logic [MAX_PIX*PIX_W-1:0] wr_pix,
    output logic [MAX_PIX*PIX_W-1:0] rd_pix,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        address,
    output logic [3*PIX_W-1:0]       w_data,
    input  logic [3*PIX_W-1:0]       r_data,
    output logic                     read_enable,
    output logic                     write_enable,
    output logic [1:0]               state_dbg
);

    localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int SUM_W  = PIX_W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                   state, state_nx;
    logic [WAIT_W-1:0]        wait_cnt;
    logic [CNT_W-1:0]         idx;
    logic [CNT_W-1:0]         rd_cnt;
    logic [CNT_W-1:0]         wr_cnt;
    logic [ADDR_W-1:0]        rd_base_q;
    logic [ADDR_W-1:0]        wr_base_q;
    logic [MAX_PIX*PIX_W-1:0] wr_pix_q;
    logic [MAX_PIX*PIX_W-1:0] rd_pix_q;

    logic                     last_wait;
    logic                     last_rd;
    logic                     last_wr;
    logic [PIX_W-1:0]         wr_sel;

    // Grey level is about s/3. It uses the series 1/4 + 1/16 + 1/64 + 1/256.
    // White (FF,FF,FF) maps to 0xFB.
    function automatic logic [PIX_W-1:0] to_grey(input logic [3*PIX_W-1:0] rgb);
        logic [SUM_W-1:0] s;
        logic [SUM_W-1:0] g;
        s = SUM_W'(rgb[3*PIX_W-1:2*PIX_W]) + SUM_W'(rgb[2*PIX_W-1:PIX_W])
          + SUM_W'(rgb[PIX_W-1:0]);
        g = (s >> 2) + (s >> 4) + (s >> 6) + (s >> 8);
        return g[PIX_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] n);
        return (n > CNT_W'(MAX_PIX)) ? CNT_W'(MAX_PIX) : n;
    endfunction

    assign last_wait = (wait_cnt == WAIT_W'(WAIT_CYC - 1));
    assign last_rd   = ((idx + CNT_W'(1)) == rd_cnt);
    assign last_wr   = ((idx + CNT_W'(1)) == wr_cnt);
    assign wr_sel    = wr_pix_q[int'(idx)*PIX_W +: PIX_W];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. The IDLE decisions use the raw counts; clamping never
    // turns a nonzero count into zero.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_rd != '0)      state_nx = S_RD;
                    else if (num_wr != '0) state_nx = S_WR;
                    else                   state_nx = S_DONE;
                end
            end
            S_RD: begin
                if (last_wait && last_rd) state_nx = (wr_cnt != '0) ? S_WR : S_DONE;
            end
            S_WR: begin
                if (last_wait && last_wr) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Burst parameters, access counters and the pixel buffers
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            idx       <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            wr_pix_q  <= '0;
            rd_pix_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rd_base_q <= rd_base;
                        wr_base_q <= wr_base;
                        rd_cnt    <= clamp(num_rd);
                        wr_cnt    <= clamp(num_wr);
                        wr_pix_q  <= wr_pix;
                        rd_pix_q  <= '0;
                        wait_cnt  <= '0;
                        idx       <= '0;
                    end
                end
                S_RD, S_WR: begin
                    if (last_wait) begin
                        wait_cnt <= '0;
                        // idx restarts at 0 when a phase ends, so the write phase
                        // begins at its own first entry.
                        if ((state == S_RD && last_rd) || (state == S_WR && last_wr)) begin
                            idx <= '0;
                        end else begin
                            idx <= idx + CNT_W'(1);
                        end
                        if (state == S_RD) begin
                            rd_pix_q[int'(idx)*PIX_W +: PIX_W] <= to_grey(r_data);
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs. The SRAM bus is forced to zero outside RD/WR, so the enables
    // can never be high in IDLE or DONE.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        address      = '0;
        w_data       = '0;
        case (state)
            S_RD: begin
                busy        = 1'b1;
                read_enable = 1'b1;
                address     = rd_base_q + ADDR_W'(idx);
            end
            S_WR: begin
                busy         = 1'b1;
                write_enable = 1'b1;
                address      = wr_base_q + ADDR_W'(idx);
`ifdef PIXEL_BURST_GREY_REPLICATE_EN
                w_data       = {wr_sel, wr_sel, wr_sel};
`else
                w_data       = {{(2*PIX_W){1'b0}}, wr_sel};
`endif
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rd_pix    = rd_pix_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_pixel_burst_engine.sv
module tb_pixel_burst_engine;

    localparam int ADDR_W   = 16;
    localparam int PIX_W    = 8;
    localparam int MAX_PIX  = 20;
    localparam int CNT_W    = 5;
    localparam int WAIT_CYC = 3;
    localparam int TW       = 4 + ADDR_W + 3*PIX_W;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic [ADDR_W-1:0]        rd_base;
    logic [ADDR_W-1:0]        wr_base;
    logic [CNT_W-1:0]         num_rd;
    logic [CNT_W-1:0]         num_wr;
    logic [MAX_PIX*PIX_W-1:0] wr_pix;
    logic [MAX_PIX*PIX_W-1:0] rd_pix;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        address;
    logic [3*PIX_W-1:0]       w_data;
    logic [3*PIX_W-1:0]       r_data;
    logic                     read_enable;
    logic                     write_enable;
    logic [1:0]               state_dbg;

    pixel_burst_engine #(
        .ADDR_W(ADDR_W), .PIX_W(PIX_W), .MAX_PIX(MAX_PIX),
        .CNT_W(CNT_W), .WAIT_CYC(WAIT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_base(rd_base), .wr_base(wr_base),
        .num_rd(num_rd), .num_wr(num_wr),
        .wr_pix(wr_pix), .rd_pix(rd_pix),
        .busy(busy), .done(done), .address(address),
        .w_data(w_data), .r_data(r_data),
        .read_enable(read_enable), .write_enable(write_enable),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model ----------------
    logic [3*PIX_W-1:0] mem [0:65535];
    always_comb r_data = read_enable ? mem[address] : '0;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [TW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference grey value from plain integer arithmetic on the channel sum
    function automatic int grey_ref(input int rgb);
        int s;
        s = ((rgb >> 16) & 255) + ((rgb >> 8) & 255) + (rgb & 255);
        return (s / 4 + s / 16 + s / 64 + s / 256) % 256;
    endfunction

    function automatic int wdata_ref(input int p);
`ifdef PIXEL_BURST_GREY_REPLICATE_EN
        return p * 32'h010101;
`else
        return p;
`endif
    endfunction

    function automatic logic [TW-1:0] bus_word(input logic b, input logic d, input logic re,
                                              input logic we, input int a, input int wd);
        return {b, d, re, we, ADDR_W'(a), (3*PIX_W)'(wd)};
    endfunction

    function automatic logic [TW-1:0] observed();
        return {busy, done, read_enable, write_enable, address, w_data};
    endfunction

    task automatic check_rd_pix(input string tag, input int rb, input int nr_c);
        for (int i = 0; i < MAX_PIX; i++) begin
            int e;
            e = (i < nr_c) ? grey_ref(int'(mem[(rb + i) % 65536])) : 0;
            check_eq($sformatf("%s_pix%0d", tag, i), 64'(rd_pix[i*PIX_W +: PIX_W]), 64'(e));
        end
    endtask

    // ---------------- driver ----------------
    // Runs one burst and compares the SRAM bus cycle by cycle against the
    // expected trace. If poke > 0, start is pulsed again in that cycle.
    task automatic run_burst(input string tag, input int rb, input int wb, input int nr,
                             input int nw, input logic [MAX_PIX*PIX_W-1:0] wp, input int poke);
        int nr_c, nw_c, total, c;
        nr_c  = (nr > MAX_PIX) ? MAX_PIX : nr;
        nw_c  = (nw > MAX_PIX) ? MAX_PIX : nw;
        total = (nr_c + nw_c) * WAIT_CYC;
        exp_q.delete();
        for (int cy = 1; cy <= total; cy++) begin
            int k;
            k = (cy - 1) / WAIT_CYC;
            if (k < nr_c) exp_q.push_back(bus_word(1'b1, 1'b0, 1'b1, 1'b0, rb + k, 0));
            else exp_q.push_back(bus_word(1'b1, 1'b0, 1'b0, 1'b1, wb + (k - nr_c),
                                          wdata_ref(int'(wp[(k - nr_c)*PIX_W +: PIX_W]))));
        end
        exp_q.push_back(bus_word(1'b0, 1'b1, 1'b0, 1'b0, 0, 0));
        exp_q.push_back(bus_word(1'b0, 1'b0, 1'b0, 1'b0, 0, 0));

        @(negedge clk);
        rd_base = ADDR_W'(rb);
        wr_base = ADDR_W'(wb);
        num_rd  = CNT_W'(nr);
        num_wr  = CNT_W'(nw);
        wr_pix  = wp;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        c = 1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check_eq($sformatf("%s_bus_c%0d", tag, c), 64'(observed()), 64'(exp_q.pop_front()));
            start = (c == poke);
            c++;
        end
        start = 1'b0;
        check_rd_pix(tag, rb, nr_c);
        // The held result and a quiet bus must remain in place after done.
        repeat (2) begin
            @(negedge clk);
            check_eq($sformatf("%s_quiet", tag), 64'(observed()), 64'(0));
        end
        check_rd_pix({tag, "_hold"}, rb, nr_c);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [MAX_PIX*PIX_W-1:0] wp;
        int rb, wb, nr, nw;

        for (int a = 0; a < 65536; a++) mem[a] = (3*PIX_W)'($urandom);
        rst = 1'b1; start = 1'b0; rd_base = '0; wr_base = '0;
        num_rd = '0; num_wr = '0; wr_pix = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_bus", 64'(observed()), 64'(0));
        check_eq("reset_rd_pix_zero", 64'(rd_pix == '0), 64'(1));
        rst = 1'b0;

        // Two reads: white then black
        mem[16'h0010] = 24'hFFFFFF;
        mem[16'h0011] = 24'h000000;
        run_burst("t1", 16'h0010, 0, 2, 0, '0, 0);
        check_eq("t1_white", 64'(rd_pix[7:0]), 64'(8'hFB));
        check_eq("t1_black", 64'(rd_pix[15:8]), 64'(8'h00));

        // One read followed by two writes
        wp = '0;
        wp[7:0]  = 8'h12;
        wp[15:8] = 8'h34;
        run_burst("t2", 16'h0020, 16'h0100, 1, 2, wp, 0);

        // Both counts zero
        run_burst("t3", 16'h0300, 16'h0400, 0, 0, wp, 0);

        // Address wrap and count clamp
        run_burst("t4_wrap", 16'hFFFF, 0, 2, 0, '0, 0);
        run_burst("t4_clamp_rd", 16'h1000, 0, 31, 0, '0, 0);
        for (int i = 0; i < MAX_PIX; i++) wp[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
        run_burst("t4_clamp_wr", 0, 16'hFFF8, 0, 25, wp, 0);

        // Start pulsed while busy is ignored
        run_burst("t5_poke", 16'h2000, 16'h3000, 2, 1, wp, 2);

        // Reset during the second read
        mem[16'h4000] = 24'hFFFFFF;
        @(negedge clk);
        rd_base = 16'h4000; wr_base = 16'h5000; num_rd = 5'd3; num_wr = 5'd2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (WAIT_CYC + 2) @(negedge clk);
        check_eq("t5_rst_partial", 64'(rd_pix[7:0]), 64'(8'hFB));
        check_eq("t5_rst_pre_addr", 64'(address), 64'(16'h4001));
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_bus", 64'(observed()), 64'(0));
        check_eq("t5_rst_rd_pix_zero", 64'(rd_pix == '0), 64'(1));
        rst = 1'b0;

        // Random bursts against the reference model
        for (int n = 0; n < 14; n++) begin
            rb = $urandom_range(0, 65535);
            wb = $urandom_range(0, 65535);
            nr = $urandom_range(0, 31);
            nw = $urandom_range(0, 31);
            if (n % 3 == 0) nr = $urandom_range(1, 6);
            for (int i = 0; i < MAX_PIX; i++) wp[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
            run_burst($sformatf("rnd%0d", n), rb, wb, nr, nw, wp, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
